// File: rtl/bit_fifo_pkg.sv
// Shared defaults and width helpers for the word-in / bit-out FIFO.
package bit_fifo_pkg;

  localparam int WORD_W_DEF      = 32;
  localparam int DEPTH_WORDS_DEF = 4;

  function automatic int ptr_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

  function automatic int idx_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

  function automatic int count_width(input int depth_words);
    return $clog2(depth_words) + 1;
  endfunction

  function automatic int avail_width(input int word_w, input int depth_words);
    return $clog2(word_w * depth_words) + 1;
  endfunction

  localparam int PTR_W_DEF   = ptr_width(DEPTH_WORDS_DEF);
  localparam int IDX_W_DEF   = idx_width(WORD_W_DEF);
  localparam int CNT_W_DEF   = count_width(DEPTH_WORDS_DEF);
  localparam int AVAIL_W_DEF = avail_width(WORD_W_DEF, DEPTH_WORDS_DEF);

endpackage

// File: rtl/bit_fifo_mem.sv
// Word storage for bit_fifo: one synchronous write port, one asynchronous read port.
module bit_fifo_mem
  import bit_fifo_pkg::*;
#(
  parameter int  WORD_W      = WORD_W_DEF,
  parameter int  DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int PTR_W       = ptr_width(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: storage is deliberately not reset; the pointers and count alone say which words are valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bit_fifo.sv
// Word-wide write side, single-bit first-word-fall-through read side (LSB of each word first).
module bit_fifo
  import bit_fifo_pkg::*;
#(
  parameter int  WORD_W      = WORD_W_DEF,
  parameter int  DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int AVAIL_W     = avail_width(WORD_W, DEPTH_WORDS)
) (
  input  logic               fifo_clk,
  input  logic               fifo_rst,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               fifo_req,
  output logic               fifo_bit,
  output logic               fifo_empty,
  output logic [AVAIL_W-1:0] bits_avail,
  output logic               underflow
);

  localparam int PTR_W = ptr_width(DEPTH_WORDS);
  localparam int IDX_W = idx_width(WORD_W);
  localparam int CNT_W = count_width(DEPTH_WORDS);

  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nx;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nx;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nx;
  logic [CNT_W-1:0]   used, used_nx;
  logic [AVAIL_W-1:0] avail_nx;
  logic               underflow_nx;
  logic [WORD_W-1:0]  head_word;
  logic               wr_fire, pop, word_done;

  // Flow control looks only at registered state, so a pop never opens a slot in the same cycle.
  assign wr_ready   = (used < CNT_W'(DEPTH_WORDS));
  assign fifo_empty = (bits_avail == '0);
  assign wr_fire    = wr_valid & wr_ready;
  assign pop        = fifo_req & ~fifo_empty;
  assign word_done  = pop & (bit_idx == IDX_W'(WORD_W - 1));
  assign fifo_bit   = ~fifo_empty & head_word[bit_idx];

  bit_fifo_mem #(
    .WORD_W      (WORD_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk   (fifo_clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    wr_ptr_nx    = wr_ptr;
    rd_ptr_nx    = rd_ptr;
    bit_idx_nx   = bit_idx;
    used_nx      = used;
    avail_nx     = bits_avail;
    underflow_nx = underflow | (fifo_req & fifo_empty);

    if (wr_fire)   wr_ptr_nx  = wr_ptr + PTR_W'(1);
    if (pop)       bit_idx_nx = word_done ? '0 : bit_idx + IDX_W'(1);
    if (word_done) rd_ptr_nx  = rd_ptr + PTR_W'(1);

    case ({wr_fire, word_done})
      2'b10:   used_nx = used + CNT_W'(1);
      2'b01:   used_nx = used - CNT_W'(1);
      default: used_nx = used;
    endcase

    case ({wr_fire, pop})
      2'b10:   avail_nx = bits_avail + AVAIL_W'(WORD_W);
      2'b01:   avail_nx = bits_avail - AVAIL_W'(1);
      2'b11:   avail_nx = bits_avail + AVAIL_W'(WORD_W - 1);
      default: avail_nx = bits_avail;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      bit_idx    <= '0;
      used       <= '0;
      bits_avail <= '0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      bit_idx    <= bit_idx_nx;
      used       <= used_nx;
      bits_avail <= avail_nx;
      underflow  <= underflow_nx;
    end
  end

endmodule

// File: tb/tb_bit_fifo.sv
// Scoreboard bench for bit_fifo: accepted words queue their bits, a monitor compares each pop.
module tb_bit_fifo;
  import bit_fifo_pkg::*;

  localparam int W  = WORD_W_DEF;
  localparam int AW = AVAIL_W_DEF;

  logic          fifo_clk = 1'b0;
  logic          fifo_rst;
  logic [W-1:0]  wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          fifo_req;
  logic          fifo_bit;
  logic          fifo_empty;
  logic [AW-1:0] bits_avail;
  logic          underflow;

  int checks    = 0;
  int errors    = 0;
  int pops_seen = 0;
  bit exp_q[$];

  logic [19:0] stream_words [20] = '{
    20'h12345, 20'h6789A, 20'hBCDEF, 20'h0F1E2, 20'hD3C4B,
    20'hA5968, 20'h7F001, 20'h00FFF, 20'hFFFFF, 20'h80001,
    20'h55555, 20'hAAAAA, 20'h13579, 20'h2468A, 20'hC0DE5,
    20'h0BEEF, 20'hFACE0, 20'h31415, 20'h92653, 20'h00001};

  logic [W-1:0] fill_words [4] = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h8000_0001, 32'hFFFF_0000};

  bit_fifo dut (
    .fifo_clk   (fifo_clk),
    .fifo_rst   (fifo_rst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .fifo_req   (fifo_req),
    .fifo_bit   (fifo_bit),
    .fifo_empty (fifo_empty),
    .bits_avail (bits_avail),
    .underflow  (underflow)
  );

  always #5 fifo_clk = ~fifo_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    wr_data  = '0;
    fifo_req = 1'b0;
  endtask

  // One clock cycle of stimulus; an accepted word queues its bits LSB first.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, output bit accepted);
    wr_valid = v;
    wr_data  = d;
    fifo_req = r;
    accepted = v && wr_ready && !fifo_rst;
    if (accepted)
      for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    @(posedge fifo_clk);
    #1;
  endtask

  task automatic pops(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, acc);
    idle();
  endtask

  task automatic write(input logic [W-1:0] d);
    bit acc;
    cycle(1'b1, d, 1'b0, acc);
    idle();
  endtask

  always @(negedge fifo_clk) begin
    if (!fifo_rst && fifo_req && !fifo_empty) begin
      pops_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_bit: pop with no queued bit, fifo_bit=%0b at %0t", fifo_bit, $time);
      end else begin
        check("stream_bit", fifo_bit, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int wi, budget, start_pops;

    fifo_rst = 1'b1;
    idle();
    #2;
    check("rst_avail", bits_avail, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_bit", fifo_bit, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_underflow", underflow, 0);
    repeat (2) @(posedge fifo_clk);
    #1;
    fifo_rst = 1'b0;

    // Single word A5: falls through immediately, then LSB-first drain.
    write(32'h0000_00A5);
    check("a5_empty", fifo_empty, 0);
    check("a5_bit0", fifo_bit, 1);
    check("a5_avail", bits_avail, 32);
    pops(1);
    check("a5_avail_31", bits_avail, 31);
    check("a5_bit1", fifo_bit, 0);
    pops(31);
    check("a5_done_empty", fifo_empty, 1);
    check("a5_done_avail", bits_avail, 0);

    // Fill to capacity, a fifth write is dropped.
    for (int i = 0; i < 4; i++) write(fill_words[i]);
    check("full_ready", wr_ready, 0);
    check("full_avail", bits_avail, 128);
    write(32'hCAFE_F00D);
    check("full_drop_avail", bits_avail, 128);
    check("full_drop_ready", wr_ready, 0);
    pops(128);
    check("full_drain_empty", fifo_empty, 1);
    check("full_drain_queue", exp_q.size(), 0);

    // Full FIFO: a write together with the word-freeing pop waits one cycle.
    for (int i = 0; i < 4; i++) write(fill_words[3 - i]);
    pops(31);
    check("edge_avail_97", bits_avail, 97);
    check("edge_ready_0", wr_ready, 0);
    cycle(1'b1, 32'h5A5A_C3C3, 1'b1, acc);
    check("edge_same_cycle_rejected", acc, 0);
    check("edge_avail_96", bits_avail, 96);
    check("edge_ready_1", wr_ready, 1);
    cycle(1'b1, 32'h5A5A_C3C3, 1'b0, acc);
    idle();
    check("edge_accepted", acc, 1);
    check("edge_avail_128", bits_avail, 128);
    pops(128);
    check("edge_drain_avail", bits_avail, 0);

    // Streaming: offer a word every cycle, pop whenever a bit is present.
    wi = 0;
    budget = 0;
    start_pops = pops_seen;
    while ((wi < 20 || !fifo_empty) && budget < 2000) begin
      cycle(wi < 20, {12'h000, stream_words[(wi < 20) ? wi : 0]}, !fifo_empty, acc);
      if (acc) wi++;
      check("stream_avail", bits_avail, exp_q.size());
      budget++;
    end
    idle();
    check("stream_in_budget", budget < 2000, 1);
    check("stream_words", wi, 20);
    check("stream_bits", pops_seen - start_pops, 640);
    check("stream_underflow", underflow, 0);

    // Underflow is sticky through later traffic.
    pops(1);
    check("uf_set", underflow, 1);
    check("uf_avail", bits_avail, 0);
    write(32'h0000_F00F);
    pops(32);
    check("uf_sticky", underflow, 1);

    // Asynchronous reset with 70 bits stored.
    write(32'hFFFF_FFFF);
    write(32'h1234_5678);
    write(32'h0F0F_0F0F);
    pops(26);
    check("ar_avail_70", bits_avail, 70);
    #2;
    fifo_rst = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h8888_8888;
    fifo_req = 1'b1;
    exp_q.delete();
    #1;
    check("ar_avail", bits_avail, 0);
    check("ar_empty", fifo_empty, 1);
    check("ar_bit", fifo_bit, 0);
    check("ar_ready", wr_ready, 1);
    check("ar_underflow", underflow, 0);
    @(posedge fifo_clk);
    #1;
    check("ar_held_avail", bits_avail, 0);
    fifo_rst = 1'b0;
    idle();
    write(32'h0000_0001);
    check("ar_new_bit", fifo_bit, 1);
    pops(32);
    check("ar_new_empty", fifo_empty, 1);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
